frame_serializer_60bit: RTL

FRAME_SERIALIZER_60BIT -- requirements
Module: frame_serializer_60bit

---
 rtl/frame_serializer_60bit_pkg.sv | 16 +
 rtl/frame_serializer_60bit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/frame_serializer_60bit_pkg.sv
// Shared frame geometry and serializer state encoding, common to the
// interleaver, deinterleaver and frame serializer.
package frame_serializer_60bit_pkg;

  localparam int FRAME_W = 60;
  localparam int ROWS    = 4;
  localparam int COLS    = 15;

  // EMPTY: shift register empty; SHIFT: shift register full; SHIFT_HOLD: both full
  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_SHIFT_HOLD = 2'd2
  } ser_state_e;

endpackage

// File: rtl/frame_serializer_60bit.sv
// Serializes 60-bit interleaved frames into LANE_W-bit beats, LSB beat first,
// with a holding register so consecutive frames stream without bubbles.
module frame_serializer_60bit
  import frame_serializer_60bit_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LANE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eof,
  output logic [15:0]        frame_cnt
);

  localparam int         BEATS     = FRAME_W / LANE_W;
  localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

  ser_state_e         state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [FRAME_W-1:0] hr_q, hr_d;
  logic [FRAME_W-1:0] sr_shifted;
  logic [5:0]         beat_q, beat_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               sr_full, hr_full;
  logic               in_xfer, beat_xfer, last_xfer;

  // A single-beat frame leaves nothing behind after the shift.
  generate
    if (LANE_W == FRAME_W) begin : g_single_beat
      assign sr_shifted = '0;
    end else begin : g_multi_beat
      assign sr_shifted = {{LANE_W{1'b0}}, sr_q[FRAME_W-1:LANE_W]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      sr_q        <= '0;
      hr_q        <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hr_q        <= hr_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hr_d        = hr_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    in_xfer     = in_valid && in_ready;
    beat_xfer   = out_valid && out_ready;
    last_xfer   = beat_xfer && (beat_q == LAST_BEAT);
    if (last_xfer) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          sr_d    = in_data;
          beat_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_xfer) begin
          beat_d = '0;
          if (in_xfer) begin
            sr_d = in_data;
          end else begin
            sr_d    = '0;
            state_d = ST_EMPTY;
          end
        end else begin
          if (beat_xfer) begin
            sr_d   = sr_shifted;
            beat_d = beat_q + 6'd1;
          end
          if (in_xfer) begin
            hr_d    = in_data;
            state_d = ST_SHIFT_HOLD;
          end
        end
      end
      ST_SHIFT_HOLD: begin
        if (last_xfer) begin
          sr_d    = hr_q;
          hr_d    = '0;
          beat_d  = '0;
          state_d = ST_SHIFT;
        end else if (beat_xfer) begin
          sr_d   = sr_shifted;
          beat_d = beat_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // The full flags are the state encoding; in_ready is held low while reset is asserted.
  always_comb begin
    sr_full   = (state_q != ST_EMPTY);
    hr_full   = (state_q == ST_SHIFT_HOLD);
    in_ready  = !hr_full && !rst;
    out_valid = sr_full;
    out_data  = sr_q[LANE_W-1:0];
    out_sof   = sr_full && (beat_q == 6'd0);
    out_eof   = sr_full && (beat_q == LAST_BEAT);
    frame_cnt = frame_cnt_q;
  end

endmodule
